// File: rtl/epu_pkg.sv
// rtl/epu_pkg.sv - shared EPU sizing constants for the weight SRAM
package epu_pkg;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 5168;
  localparam int BIAS_BASE = 5120;
endpackage

// File: rtl/weight_sram_loader.sv
// rtl/weight_sram_loader.sv - streams host words into the weight SRAM system-load port
// One-stage registered write path; accumulates a 32-bit checksum of accepted words.
module weight_sram_loader #(
  parameter int DEPTH  = epu_pkg::DEPTH,
  parameter int ADDR_W = epu_pkg::ADDR_W,
  parameter int DATA_W = epu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_abort,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_system_load,
  output logic              o_system_CEB,
  output logic              o_system_WEB,
  output logic [ADDR_W-1:0] o_system_A,
  output logic [DATA_W-1:0] o_system_DI,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_W+1:0] L_DEPTH = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   L_REM_1 = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_ADR_1 = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_addr;
  logic              r_aborted;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_ceb;
  logic              r_web;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_di;
  logic [31:0]       r_checksum;

  logic [ADDR_W+1:0] w_end;
  logic              w_range_ok;
  logic              w_ready;
  logic              w_accept;

  // Extra headroom bit so base+length cannot overflow before the range compare.
  assign w_end      = {2'b00, i_base_addr} + {1'b0, i_length};
  assign w_range_ok = (w_end <= L_DEPTH);
  assign w_ready    = (r_state == LOAD) && (r_remaining != '0) && !i_abort;
  assign w_accept   = i_data_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_addr      <= '0;
      r_aborted   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ceb       <= 1'b1;
      r_web       <= 1'b1;
      r_a         <= '0;
      r_di        <= '0;
      r_checksum  <= '0;
    end else begin
      r_ceb  <= 1'b1;
      r_web  <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (!w_range_ok) begin
              r_err <= 1'b1;
            end else begin
              r_addr      <= i_base_addr;
              r_remaining <= i_length;
              r_checksum  <= '0;
              r_aborted   <= 1'b0;
              r_busy      <= 1'b1;
              if (i_length == '0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          if (i_abort) begin
            r_state   <= DRAIN;
            r_aborted <= 1'b1;
          end else if (w_accept) begin
            r_ceb       <= 1'b0;
            r_web       <= 1'b0;
            r_a         <= r_addr;
            r_di        <= i_data;
            r_addr      <= r_addr + L_ADR_1;
            r_remaining <= r_remaining - L_REM_1;
            r_checksum  <= r_checksum + 32'(i_data);
            if (r_remaining == L_REM_1) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_err   <= r_aborted;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data_ready  = w_ready;
  assign o_system_load = r_busy;
  assign o_busy        = r_busy;
  assign o_system_CEB  = r_ceb;
  assign o_system_WEB  = r_web;
  assign o_system_A    = r_a;
  assign o_system_DI   = r_di;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_checksum    = r_checksum;
endmodule

// File: tb/tb_weight_sram_loader.sv
// tb/tb_weight_sram_loader.sv - self-checking bench for weight_sram_loader
module tb_weight_sram_loader;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5168;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_length;
  logic              i_abort;
  logic              i_data_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_data_ready;
  logic              o_system_load;
  logic              o_system_CEB;
  logic              o_system_WEB;
  logic [ADDR_W-1:0] o_system_A;
  logic [DATA_W-1:0] o_system_DI;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [31:0]       o_checksum;

  weight_sram_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_length(i_length), .i_abort(i_abort), .i_data_valid(i_data_valid),
    .i_data(i_data), .o_data_ready(o_data_ready), .o_system_load(o_system_load),
    .o_system_CEB(o_system_CEB), .o_system_WEB(o_system_WEB),
    .o_system_A(o_system_A), .o_system_DI(o_system_DI), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_checksum(o_checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nwr    = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                c;
  } wr_t;
  wr_t wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Every SRAM write must match the oldest accepted word, one cycle after its acceptance.
  always @(negedge clk) begin : mon
    wr_t w;
    if (o_system_CEB === 1'b0) begin
      nwr++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL write_unexpected A=%0d DI=%0h (cycle %0d)", o_system_A, o_system_DI, cyc);
      end else begin
        w = wq.pop_front();
        check("write_addr", 64'(o_system_A), 64'(w.a));
        check("write_data", 64'(o_system_DI), 64'(w.d));
        check("write_cycle", 64'(cyc), 64'(w.c));
        check("write_web", 64'(o_system_WEB), 64'(0));
      end
    end else begin
      check("idle_web", 64'(o_system_WEB), 64'(1));
      if (wq.size() > 0 && wq[0].c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL write_missing exp_A=%0d exp_DI=%0h (cycle %0d)", wq[0].a, wq[0].d, cyc);
        void'(wq.pop_front());
      end
    end
  end

  // mode 0: valid always, 1: every other cycle, 2: random valid plus stray starts.
  task automatic run_load(input int base, input int len, input int mode,
                          input int abort_at, input bit seq_data);
    logic [31:0]       sum;
    logic              v;
    logic [DATA_W-1:0] d;
    int acc, k;
    bit aborted, fin;
    sum = '0; acc = 0; k = 0; aborted = 0; fin = 0;
    @(negedge clk);
    i_start = 1'b1; i_base_addr = ADDR_W'(base); i_length = (ADDR_W+1)'(len);
    @(negedge clk);
    i_start = 1'b0;
    #1;
    check("busy_after_start", 64'(o_busy), 64'(1));
    check("csum_cleared", 64'(o_checksum), 64'(0));
    while (!fin) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((k % 2) == 0) : 1'(($urandom % 3) != 0);
      d = seq_data ? DATA_W'(32'h11 * (acc + 1)) : DATA_W'($urandom);
      i_data_valid = v;
      i_data       = d;
      i_abort      = 1'(acc == abort_at);
      i_start      = (mode == 2) && (($urandom % 8) == 0);
      i_base_addr  = ADDR_W'($urandom);
      i_length     = (ADDR_W+1)'($urandom);
      #1;
      check("ready_load", 64'(o_data_ready), 64'((acc < len) && !i_abort));
      check("busy_load", 64'(o_busy), 64'(1));
      check("sysload_load", 64'(o_system_load), 64'(1));
      if (i_abort) begin
        aborted = 1;
        fin = 1;
      end else if (v) begin
        wq.push_back('{ADDR_W'(base + acc), d, cyc + 1});
        sum += 32'(d);
        acc++;
        if (acc == len) fin = 1;
      end
      k++;
      if (k > 5000) begin
        checks++;
        errors++;
        $display("FAIL load_timeout acc=%0d len=%0d", acc, len);
        fin = 1;
      end
      @(negedge clk);
    end
    i_abort = 1'b0; i_start = 1'b0;
    i_data_valid = 1'b1;
    #1;
    check("drain_ready", 64'(o_data_ready), 64'(0));
    check("drain_done", 64'(o_done), 64'(0));
    check("drain_busy", 64'(o_busy), 64'(1));
    @(negedge clk);
    i_data_valid = 1'b0;
    #1;
    check("done_pulse", 64'(o_done), 64'(1));
    check("done_err", 64'(o_err), 64'(aborted));
    check("done_checksum", 64'(o_checksum), 64'(sum));
    check("done_busy", 64'(o_busy), 64'(1));
    check("done_queue_empty", 64'(wq.size()), 64'(0));
    @(negedge clk);
    #1;
    check("post_done", 64'(o_done), 64'(0));
    check("post_err", 64'(o_err), 64'(0));
    check("post_busy", 64'(o_busy), 64'(0));
    check("post_sysload", 64'(o_system_load), 64'(0));
    check("post_checksum_hold", 64'(o_checksum), 64'(sum));
  endtask

  typedef struct {
    int base;
    int len;
    bit err;
    bit done;
  } vec_t;

  initial begin : main
    vec_t tbl[6];
    int n0, len, base;
    logic [DATA_W-1:0] d;

    tbl[0] = '{5160, 16, 1'b1, 1'b0};
    tbl[1] = '{100, 0, 1'b0, 1'b1};
    tbl[2] = '{5168, 0, 1'b0, 1'b1};
    tbl[3] = '{5169, 0, 1'b1, 1'b0};
    tbl[4] = '{0, 5169, 1'b1, 1'b0};
    tbl[5] = '{16383, 32767, 1'b1, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_length = '0;
    i_abort = 1'b0; i_data_valid = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sysload", 64'(o_system_load), 64'(0));
    check("rst_ceb", 64'(o_system_CEB), 64'(1));
    check("rst_web", 64'(o_system_WEB), 64'(1));
    check("rst_a", 64'(o_system_A), 64'(0));
    check("rst_di", 64'(o_system_DI), 64'(0));
    check("rst_ready", 64'(o_data_ready), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    check("rst_checksum", 64'(o_checksum), 64'(0));
    rst = 1'b0;

    n0 = nwr;
    run_load(0, 4, 0, -1, 1'b1);
    check("seq4_writes", 64'(nwr - n0), 64'(4));
    check("seq4_checksum", 64'(o_checksum), 64'(32'hAA));

    n0 = nwr;
    run_load(5120, 3, 1, -1, 1'b0);
    check("bias_writes", 64'(nwr - n0), 64'(3));

    n0 = nwr;
    run_load(300, 8, 0, 2, 1'b0);
    check("abort_writes", 64'(nwr - n0), 64'(2));

    run_load(DEPTH - 8, 8, 1, -1, 1'b0);

    // Reset in the middle of a load after one accepted word.
    @(negedge clk);
    i_start = 1'b1; i_base_addr = ADDR_W'(200); i_length = (ADDR_W+1)'(8);
    @(negedge clk);
    i_start = 1'b0; d = 32'hDEAD_BEEF; i_data_valid = 1'b1; i_data = d;
    #1;
    check("rstmid_ready", 64'(o_data_ready), 64'(1));
    wq.push_back('{ADDR_W'(200), d, cyc + 1});
    @(negedge clk);
    i_data_valid = 1'b1; i_data = 32'h1234_5678; rst = 1'b1;
    #1;
    check("rstmid_csum_before", 64'(o_checksum), 64'(32'hDEAD_BEEF));
    @(negedge clk);
    #1;
    check("rstmid_sysload", 64'(o_system_load), 64'(0));
    check("rstmid_ceb", 64'(o_system_CEB), 64'(1));
    check("rstmid_busy", 64'(o_busy), 64'(0));
    check("rstmid_checksum", 64'(o_checksum), 64'(0));
    check("rstmid_ready", 64'(o_data_ready), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    i_data_valid = 1'b0;
    #1;
    check("rstmid_no_pending", 64'(wq.size()), 64'(0));

    // Start requests that never enter LOAD: range errors and zero-length loads.
    for (int i = 0; i < 6; i++) begin
      n0 = nwr;
      @(negedge clk);
      i_start = 1'b1; i_base_addr = ADDR_W'(tbl[i].base); i_length = (ADDR_W+1)'(tbl[i].len);
      @(negedge clk);
      i_start = 1'b0;
      #1;
      check($sformatf("tbl%0d_err", i), 64'(o_err), 64'(tbl[i].err));
      check($sformatf("tbl%0d_done", i), 64'(o_done), 64'(tbl[i].done));
      check($sformatf("tbl%0d_busy", i), 64'(o_busy), 64'(tbl[i].done));
      check($sformatf("tbl%0d_sysload", i), 64'(o_system_load), 64'(tbl[i].done));
      check($sformatf("tbl%0d_checksum", i), 64'(o_checksum), 64'(0));
      check($sformatf("tbl%0d_ready", i), 64'(o_data_ready), 64'(0));
      @(negedge clk);
      #1;
      check($sformatf("tbl%0d_err_after", i), 64'(o_err), 64'(0));
      check($sformatf("tbl%0d_done_after", i), 64'(o_done), 64'(0));
      check($sformatf("tbl%0d_busy_after", i), 64'(o_busy), 64'(0));
      check($sformatf("tbl%0d_no_write", i), 64'(nwr - n0), 64'(0));
    end

    for (int i = 0; i < 30; i++) begin
      len  = 1 + int'($urandom % 40);
      base = int'($urandom % (DEPTH - len + 1));
      run_load(base, len, int'($urandom % 3),
               (($urandom % 4) == 0) ? int'($urandom % len) : -1, 1'b0);
      repeat ($urandom % 3) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    #1;
    check("final_queue_empty", 64'(wq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
